// File: rtl/prog_clock_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Holds the run/stop state encoding and the divisor clamp used for N=0/1.
package prog_clock_div_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    // Smallest effective period; divisors 0 and 1 both collapse to this.
    localparam int NEFF_CLAMP = 1;

endpackage

// File: rtl/prog_clock_div.sv
// Programmable clock divider with a double-buffered divisor: new divisors wait in a
// pending register and only take effect on a period boundary, or at once while stopped.
module prog_clock_div
    import prog_clock_div_pkg::*;
#(
    parameter int WIDTH       = 17,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_clock,
    output logic             tick,
    output logic             div_ack,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pending;
    logic             r_busy;
    logic             r_div_clock;
    logic             r_tick;
    logic             r_div_ack;

    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_active_next;
    logic [WIDTH-1:0] w_pending_next;
    logic             w_busy_next;
    logic             w_div_clock_next;
    logic             w_tick_next;
    logic             w_div_ack_next;

    logic [WIDTH-1:0] w_neff;
    logic             w_run;
    logic             w_wrap;
    logic             w_apply;

    assign w_neff  = (r_active < WIDTH'(2)) ? WIDTH'(NEFF_CLAMP) : r_active;
    assign w_run   = (r_state == RUNNING) && enable;
    assign w_wrap  = w_run && (r_cnt == (w_neff - WIDTH'(1)));
    // A pending divisor lands on a period boundary, or straight away when idle.
    assign w_apply = r_busy && ((r_state == STOPPED) || w_wrap);

    // NOTE: state flops use non-blocking assignments and a synchronous reset;
    // every combinational next-value below is given a default first so no latch forms.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= STOPPED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = enable ? RUNNING : STOPPED;
        w_cnt_next       = '0;
        w_tick_next      = 1'b0;
        w_div_clock_next = 1'b0;
        w_active_next    = r_active;
        w_pending_next   = r_pending;
        w_busy_next      = r_busy;
        w_div_ack_next   = 1'b0;

        if (w_run) begin
            if (w_wrap) begin
                w_tick_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + WIDTH'(1);
            end
            w_div_clock_next = (w_neff > WIDTH'(1)) && (w_cnt_next >= (w_neff >> 1));
        end

        // A load racing an activation wins over the older pending value, so the
        // overwritten sequence still yields a single acknowledge.
        if (w_apply) begin
            w_active_next  = div_load ? div_in : r_pending;
            w_pending_next = div_load ? div_in : r_pending;
            w_busy_next    = 1'b0;
            w_div_ack_next = 1'b1;
        end else if (div_load) begin
            w_pending_next = div_in;
            w_busy_next    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_active    <= WIDTH'(DEFAULT_DIV);
            r_pending   <= '0;
            r_busy      <= 1'b0;
            r_div_clock <= 1'b0;
            r_tick      <= 1'b0;
            r_div_ack   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_active    <= w_active_next;
            r_pending   <= w_pending_next;
            r_busy      <= w_busy_next;
            r_div_clock <= w_div_clock_next;
            r_tick      <= w_tick_next;
            r_div_ack   <= w_div_ack_next;
        end
    end

    assign div_clock = r_div_clock;
    assign tick      = r_tick;
    assign div_ack   = r_div_ack;
    assign busy      = r_busy;

endmodule

// File: tb/tb_prog_clock_div.sv
// Self-checking bench for prog_clock_div: directed scenarios then random traffic,
// every cycle compared against a period/position reference model.
module tb_prog_clock_div;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             div_clock;
    logic             tick;
    logic             div_ack;
    logic             busy;

    int errors = 0;
    int checks = 0;

    // Reference model: running flag, position within the current period,
    // active divisor and an optional pending divisor.
    bit   m_run;
    int   m_pos;
    int   m_active;
    bit   m_pend_v;
    int   m_pend;
    logic e_clk, e_tick, e_ack, e_busy;

    prog_clock_div #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .div_in   (div_in),
        .div_load (div_load),
        .div_clock(div_clock),
        .tick     (tick),
        .div_ack  (div_ack),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    function automatic int neff(input int n);
        return (n < 2) ? 1 : n;
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit ld, input int din);
        bit boundary;
        bit activate;
        int len;
        if (rst) begin
            m_run = 0; m_pos = 0; m_active = DEFAULT_DIV; m_pend_v = 0; m_pend = 0;
            e_clk = 0; e_tick = 0; e_ack = 0; e_busy = 0;
            return;
        end
        len      = neff(m_active);
        boundary = m_run && en && (((m_pos + 1) % len) == 0);
        activate = m_pend_v && (!m_run || boundary);
        if (ld) begin
            m_pend   = din;
            m_pend_v = 1;
        end
        e_ack = 0;
        if (activate) begin
            m_active = m_pend;
            m_pend_v = 0;
            e_ack    = 1;
        end
        if (m_run && en) begin
            m_pos  = (m_pos + 1) % len;
            e_tick = (m_pos == 0);
        end else begin
            m_pos  = 0;
            e_tick = 0;
        end
        m_run  = en;
        len    = neff(m_active);
        e_clk  = m_run && (len > 1) && (m_pos >= len / 2);
        e_busy = m_pend_v;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input bit ld, input logic [WIDTH-1:0] din);
        reset    = rst;
        enable   = en;
        div_load = ld;
        div_in   = din;
        model_step(rst, en, ld, int'(din));
        @(posedge clock);
        #1;
        check("div_clock", div_clock, e_clk);
        check("tick", tick, e_tick);
        check("div_ack", div_ack, e_ack);
        check("busy", busy, e_busy);
        check("ack_busy_exclusive", div_ack & busy, 1'b0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, '0);
    endtask

    initial begin
        int ticks;
        // Reset overrides enable and load.
        cycle(1, 1, 1, 8'd9);
        cycle(1, 0, 0, '0);

        // Default divisor 4: 0,0,1,1 pattern, first tick 4 cycles after enable.
        run(13);

        // Load 5 mid-period; current period completes as 4.
        cycle(0, 1, 1, 8'd5);
        run(16);

        // Degenerate divisors 0 and 1, then 2.
        cycle(0, 1, 1, 8'd0);
        run(6);
        cycle(0, 1, 1, 8'd1);
        run(6);
        cycle(0, 1, 1, 8'd2);
        run(8);

        // Two loads within one period of 8: one ack, active ends up 3.
        cycle(0, 1, 1, 8'd8);
        run(4);
        cycle(0, 1, 1, 8'd6);
        cycle(0, 1, 1, 8'd3);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 0, '0);
            ticks += int'(div_ack);
        end
        check("single_ack_for_overwrite", ticks == 1, 1'b1);

        // Stop at cnt=2 of N=4, restart three cycles later.
        cycle(0, 1, 1, 8'd4);
        run(6);
        for (int i = 0; i < 8 && m_pos != 2; i++) cycle(0, 1, 0, '0);
        check("aligned_to_cnt2", m_pos == 2, 1'b1);
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        run(10);

        // Reset while N=7 is pending; default divisor returns, no ack.
        cycle(0, 1, 1, 8'd9);
        run(12);
        cycle(0, 1, 1, 8'd7);
        cycle(1, 1, 0, '0);
        run(10);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 7) == 0,
                  8'($urandom_range(0, 9)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_clock_div.md
PROG_CLOCK_DIV -- requirements
Module: prog_clock_div

Interface
REQ-001 Parameter WIDTH, default 17: width of divisor and period counter.
REQ-002 Parameter DEFAULT_DIV, default 100000: active divisor after reset; must fit in WIDTH bits.
REQ-003 clock  input  1  sole clock; all logic rises on its positive edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = run divider, 0 = stop and clear.
REQ-006 div_in  input  WIDTH  requested divisor N.
REQ-007 div_load  input  1  one-cycle strobe; captures div_in into the pending register.
REQ-008 div_clock  output  1  registered divided clock, period N clocks.
REQ-009 tick  output  1  registered one-cycle pulse at each period start.
REQ-010 div_ack  output  1  registered one-cycle pulse when a pending divisor becomes active.
REQ-011 busy  output  1  high while a divisor is pending and not yet active.

Function
REQ-012 The block SHALL have two states, STOPPED and RUNNING.
- STOPPED -> RUNNING when enable=1.
- RUNNING -> STOPPED when enable=0.
REQ-013 In STOPPED, the block SHALL hold cnt=0, div_clock=0 and tick=0.
REQ-014 In RUNNING, cnt SHALL advance 0..Neff-1 and wrap to 0.
- Neff = N for N>=2.
- Neff = 1 for N=0 or N=1.
REQ-015 div_clock SHALL equal (new cnt >= Neff/2, integer division), registered on the same edge as cnt.
- Odd N: low floor(N/2) cycles, high ceil(N/2) cycles.
REQ-016 For Neff=1, div_clock SHALL stay 0 and tick SHALL assert on every RUNNING cycle.
REQ-017 tick SHALL be 1 for exactly the cycle in which cnt has just wrapped from Neff-1 to 0.
- First tick after the STOPPED -> RUNNING transition comes Neff cycles after entry, never at entry.
REQ-018 div_load=1 SHALL capture div_in into pending and set busy=1 on the next edge.
- A later div_load before activation overwrites pending (last write wins).
- Only one div_ack is issued for the overwritten sequence.
REQ-019 While RUNNING, pending SHALL become active only on the wrap edge.
- Same edge: busy->0, div_ack=1 for one cycle.
- The new period starts at cnt=0 using the new N; no truncated or stretched period occurs.
REQ-020 While STOPPED, pending SHALL become active on the edge after capture, with div_ack=1 and busy->0.
REQ-021 div_load coinciding with a wrap edge while busy=0 SHALL NOT apply on that edge; it takes effect at the following wrap.
REQ-022 enable falling mid-period SHALL clear cnt, div_clock and tick on the next edge.
- Pending and busy are retained.
REQ-023 div_ack SHALL never coincide with busy=1 in the same cycle.

Reset
REQ-024 reset=1 SHALL, on the next edge, set the following, overriding enable and div_load:
- state=STOPPED, cnt=0, active=DEFAULT_DIV, pending=0, busy=0;
- div_clock=0, tick=0, div_ack=0.
REQ-025 Reset asserted mid-period or while busy SHALL discard the pending divisor without issuing div_ack.

Structure
REQ-026 Shared package prog_clock_div_pkg SHALL hold the state enum (STOPPED, RUNNING) and the Neff-clamp constant (1).
REQ-027 Implementation SHALL be a single flat module; no sub-module is required.
REQ-028 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-029 WIDTH=8, DEFAULT_DIV=4, enable held 1 -> div_clock pattern 0,0,1,1 repeating; tick every 4th cycle; first tick 4 cycles after enable.
REQ-030 Load 5 mid-period of N=4 -> current period completes as 4; div_ack on the wrap edge; then div_clock low 2 / high 3; tick every 5 cycles.
REQ-031 Load 0, then load 1 -> each gives tick on every cycle with div_clock=0; load 2 -> div_clock toggles every cycle; tick every 2nd cycle.
REQ-032 Loads of 6 then 3 within one period -> single div_ack at the wrap; active N=3; busy low afterward.
REQ-033 enable dropped at cnt=2 of N=4, then reasserted 3 cycles later -> outputs 0 while stopped; first tick 4 cycles after re-enable.
REQ-034 reset asserted while busy with N=7 pending -> all outputs 0; active=DEFAULT_DIV; no div_ack observed.
